// File: rtl/rs_branch.sv
// rs_branch: branch reservation station with CDB wakeup, oldest-ready select and a registered issue stage.
// Optional feature macro BR_RS_DISP_BYPASS_EN: a dispatching operand captures a same-cycle CDB broadcast.
`ifndef ALU_OP_SEL
`define ALU_OP_SEL 4
`endif
`ifndef RV32_DATA_WIDTH
`define RV32_DATA_WIDTH 32
`endif
`ifndef RV32_PC_WIDTH
`define RV32_PC_WIDTH 32
`endif

module rs_branch #(
    parameter int RS_DEPTH   = 4,
    parameter int TAG_WIDTH  = 6,
    parameter int OP_WIDTH   = `ALU_OP_SEL,
    parameter int DATA_WIDTH = `RV32_DATA_WIDTH,
    parameter int PC_WIDTH   = `RV32_PC_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_disp_vld,
    output logic                  o_disp_rdy,
    input  logic                  i_disp_is_jal,
    input  logic                  i_disp_is_jalr,
    input  logic [OP_WIDTH-1:0]   i_disp_alu_op_sel,
    input  logic [PC_WIDTH-1:0]   i_disp_pc,
    input  logic [PC_WIDTH-1:0]   i_disp_pred_jmpaddr,
    input  logic [DATA_WIDTH-1:0] i_disp_imm,
    input  logic [TAG_WIDTH-1:0]  i_disp_rob_tag,
    input  logic                  i_disp_rs1_rdy,
    input  logic [DATA_WIDTH-1:0] i_disp_rs1,
    input  logic [TAG_WIDTH-1:0]  i_disp_rs1_tag,
    input  logic                  i_disp_rs2_rdy,
    input  logic [DATA_WIDTH-1:0] i_disp_rs2,
    input  logic [TAG_WIDTH-1:0]  i_disp_rs2_tag,
    input  logic                  i_cdb_vld,
    input  logic [TAG_WIDTH-1:0]  i_cdb_tag,
    input  logic [DATA_WIDTH-1:0] i_cdb_data,
    input  logic                  i_iss_stall,
    output logic                  o_iss_vld,
    output logic                  o_iss_is_jal,
    output logic                  o_iss_is_jalr,
    output logic [OP_WIDTH-1:0]   o_iss_alu_op_sel,
    output logic [PC_WIDTH-1:0]   o_iss_pc,
    output logic [DATA_WIDTH-1:0] o_iss_imm,
    output logic [PC_WIDTH-1:0]   o_iss_pred_jmpaddr,
    output logic [DATA_WIDTH-1:0] o_iss_rs1,
    output logic [DATA_WIDTH-1:0] o_iss_rs2,
    output logic [TAG_WIDTH-1:0]  o_iss_rob_tag
);

    localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    typedef struct packed {
        logic                  is_jal;
        logic                  is_jalr;
        logic [OP_WIDTH-1:0]   op_sel;
        logic [PC_WIDTH-1:0]   pc;
        logic [PC_WIDTH-1:0]   pred;
        logic [DATA_WIDTH-1:0] imm;
        logic [TAG_WIDTH-1:0]  rob_tag;
        logic                  rs1_rdy;
        logic [DATA_WIDTH-1:0] rs1;
        logic [TAG_WIDTH-1:0]  rs1_tag;
        logic                  rs2_rdy;
        logic [DATA_WIDTH-1:0] rs2;
        logic [TAG_WIDTH-1:0]  rs2_tag;
    } entry_t;

    entry_t              ent_r [RS_DEPTH];
    logic [RS_DEPTH-1:0] valid_r;
    // age_r[i][j] set means entry i was dispatched before entry j
    logic [RS_DEPTH-1:0] age_r [RS_DEPTH];

    logic [RS_DEPTH-1:0] ready_s;
    logic [RS_DEPTH-1:0] oldest_s;
    logic                found_s;
    logic [IDX_W-1:0]    sel_idx_s;
    logic [IDX_W-1:0]    free_idx_s;
    logic                disp_rdy_s;
    logic                disp_fire_s;
    logic                load_s;
    logic                issue_fire_s;
    entry_t              disp_ent_s;

    // Oldest-ready select, free-slot search and handshake qualifiers
    always_comb begin
        ready_s  = '0;
        oldest_s = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            ready_s[i] = valid_r[i] & ent_r[i].rs1_rdy & ent_r[i].rs2_rdy;
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            oldest_s[i] = ready_s[i];
            for (int j = 0; j < RS_DEPTH; j++) begin
                if ((j != i) && ready_s[j] && !age_r[i][j]) begin
                    oldest_s[i] = 1'b0;
                end else begin
                    oldest_s[i] = oldest_s[i];
                end
            end
        end
        found_s    = |oldest_s;
        sel_idx_s  = '0;
        free_idx_s = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (oldest_s[i]) begin
                sel_idx_s = IDX_W'(i);
            end else begin
                sel_idx_s = sel_idx_s;
            end
            if (!valid_r[i]) begin
                free_idx_s = IDX_W'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
        disp_rdy_s   = ~(&valid_r);
        disp_fire_s  = i_disp_vld & disp_rdy_s & ~i_flush;
        load_s       = ~o_iss_vld | ~i_iss_stall;
        issue_fire_s = load_s & found_s & ~i_flush;
    end

    // Assemble the entry image written on dispatch
    always_comb begin
        disp_ent_s.is_jal  = i_disp_is_jal;
        disp_ent_s.is_jalr = i_disp_is_jalr;
        disp_ent_s.op_sel  = i_disp_alu_op_sel;
        disp_ent_s.pc      = i_disp_pc;
        disp_ent_s.pred    = i_disp_pred_jmpaddr;
        disp_ent_s.imm     = i_disp_imm;
        disp_ent_s.rob_tag = i_disp_rob_tag;
        disp_ent_s.rs1_rdy = i_disp_rs1_rdy;
        disp_ent_s.rs1     = i_disp_rs1;
        disp_ent_s.rs1_tag = i_disp_rs1_tag;
        disp_ent_s.rs2_rdy = i_disp_rs2_rdy;
        disp_ent_s.rs2     = i_disp_rs2;
        disp_ent_s.rs2_tag = i_disp_rs2_tag;
`ifdef BR_RS_DISP_BYPASS_EN
        if (!i_disp_rs1_rdy && i_cdb_vld && (i_cdb_tag == i_disp_rs1_tag)) begin
            disp_ent_s.rs1_rdy = 1'b1;
            disp_ent_s.rs1     = i_cdb_data;
        end else begin
            disp_ent_s.rs1_rdy = i_disp_rs1_rdy;
        end
        if (!i_disp_rs2_rdy && i_cdb_vld && (i_cdb_tag == i_disp_rs2_tag)) begin
            disp_ent_s.rs2_rdy = 1'b1;
            disp_ent_s.rs2     = i_cdb_data;
        end else begin
            disp_ent_s.rs2_rdy = i_disp_rs2_rdy;
        end
`endif
    end

    assign o_disp_rdy = disp_rdy_s;

    // Entry storage, age matrix and issue-stage registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_r            <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                age_r[i] <= '0;
            end
            o_iss_vld          <= 1'b0;
            o_iss_is_jal       <= 1'b0;
            o_iss_is_jalr      <= 1'b0;
            o_iss_alu_op_sel   <= '0;
            o_iss_pc           <= '0;
            o_iss_imm          <= '0;
            o_iss_pred_jmpaddr <= '0;
            o_iss_rs1          <= '0;
            o_iss_rs2          <= '0;
            o_iss_rob_tag      <= '0;
        end else if (i_flush) begin
            valid_r   <= '0;
            o_iss_vld <= 1'b0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (valid_r[i] && i_cdb_vld && !ent_r[i].rs1_rdy && (ent_r[i].rs1_tag == i_cdb_tag)) begin
                    ent_r[i].rs1_rdy <= 1'b1;
                    ent_r[i].rs1     <= i_cdb_data;
                end
                if (valid_r[i] && i_cdb_vld && !ent_r[i].rs2_rdy && (ent_r[i].rs2_tag == i_cdb_tag)) begin
                    ent_r[i].rs2_rdy <= 1'b1;
                    ent_r[i].rs2     <= i_cdb_data;
                end
            end
            if (issue_fire_s) begin
                valid_r[sel_idx_s] <= 1'b0;
            end
            // new entry is younger than everything currently valid
            if (disp_fire_s) begin
                ent_r[free_idx_s]   <= disp_ent_s;
                valid_r[free_idx_s] <= 1'b1;
                age_r[free_idx_s]   <= '0;
                for (int j = 0; j < RS_DEPTH; j++) begin
                    age_r[j][free_idx_s] <= valid_r[j];
                end
            end
            if (load_s) begin
                if (found_s) begin
                    o_iss_vld          <= 1'b1;
                    o_iss_is_jal       <= ent_r[sel_idx_s].is_jal;
                    o_iss_is_jalr      <= ent_r[sel_idx_s].is_jalr;
                    o_iss_alu_op_sel   <= ent_r[sel_idx_s].op_sel;
                    o_iss_pc           <= ent_r[sel_idx_s].pc;
                    o_iss_imm          <= ent_r[sel_idx_s].imm;
                    o_iss_pred_jmpaddr <= ent_r[sel_idx_s].pred;
                    o_iss_rs1          <= ent_r[sel_idx_s].rs1;
                    o_iss_rs2          <= ent_r[sel_idx_s].rs2;
                    o_iss_rob_tag      <= ent_r[sel_idx_s].rob_tag;
                end else begin
                    o_iss_vld <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_branch.sv
// tb_rs_branch: directed plus random stimulus for rs_branch, checked against an age-ordered queue model.
// Honours BR_RS_DISP_BYPASS_EN the same way the design does.
module tb_rs_branch;

    localparam int D  = 4;
    localparam int TW = 6;
    localparam int OW = 4;
    localparam int DW = 32;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst_n, flush, disp_vld, disp_rdy;
    logic          disp_is_jal, disp_is_jalr;
    logic [OW-1:0] disp_op;
    logic [PW-1:0] disp_pc, disp_pred;
    logic [DW-1:0] disp_imm;
    logic [TW-1:0] disp_rob;
    logic          disp_r1ok, disp_r2ok;
    logic [DW-1:0] disp_r1, disp_r2;
    logic [TW-1:0] disp_t1, disp_t2;
    logic          cdb_vld;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_data;
    logic          stall;
    logic          iss_vld, iss_is_jal, iss_is_jalr;
    logic [OW-1:0] iss_op;
    logic [PW-1:0] iss_pc, iss_pred;
    logic [DW-1:0] iss_imm, iss_rs1, iss_rs2;
    logic [TW-1:0] iss_rob;

    always #5 clk = ~clk;

    rs_branch #(.RS_DEPTH(D), .TAG_WIDTH(TW), .OP_WIDTH(OW), .DATA_WIDTH(DW), .PC_WIDTH(PW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
        .i_disp_vld(disp_vld), .o_disp_rdy(disp_rdy),
        .i_disp_is_jal(disp_is_jal), .i_disp_is_jalr(disp_is_jalr),
        .i_disp_alu_op_sel(disp_op), .i_disp_pc(disp_pc), .i_disp_pred_jmpaddr(disp_pred),
        .i_disp_imm(disp_imm), .i_disp_rob_tag(disp_rob),
        .i_disp_rs1_rdy(disp_r1ok), .i_disp_rs1(disp_r1), .i_disp_rs1_tag(disp_t1),
        .i_disp_rs2_rdy(disp_r2ok), .i_disp_rs2(disp_r2), .i_disp_rs2_tag(disp_t2),
        .i_cdb_vld(cdb_vld), .i_cdb_tag(cdb_tag), .i_cdb_data(cdb_data),
        .i_iss_stall(stall), .o_iss_vld(iss_vld),
        .o_iss_is_jal(iss_is_jal), .o_iss_is_jalr(iss_is_jalr), .o_iss_alu_op_sel(iss_op),
        .o_iss_pc(iss_pc), .o_iss_imm(iss_imm), .o_iss_pred_jmpaddr(iss_pred),
        .o_iss_rs1(iss_rs1), .o_iss_rs2(iss_rs2), .o_iss_rob_tag(iss_rob)
    );

    typedef struct packed {
        logic          is_jal;
        logic          is_jalr;
        logic [OW-1:0] op;
        logic [PW-1:0] pc;
        logic [PW-1:0] pred;
        logic [DW-1:0] imm;
        logic [TW-1:0] rob;
        logic          r1ok;
        logic [DW-1:0] r1;
        logic [TW-1:0] t1;
        logic          r2ok;
        logic [DW-1:0] r2;
        logic [TW-1:0] t2;
    } m_ent_t;

    m_ent_t mq[$];      // waiting ops, oldest first
    m_ent_t m_iss;
    bit     m_vld;
    bit     m_zeroed;
    int     nvec = 0;
    int     nerr = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock: advance the model from the current inputs, clock the DUT, compare.
    task automatic cycle();
        m_ent_t e;
        int     sel;
        bit     room;
        if (!rst_n) begin
            mq.delete();
            m_vld    = 1'b0;
            m_iss    = '0;
            m_zeroed = 1'b1;
        end else if (flush) begin
            mq.delete();
            m_vld = 1'b0;
        end else begin
            room = (mq.size() < D);
            sel  = -1;
            for (int i = 0; i < mq.size(); i++) begin
                if (sel < 0 && mq[i].r1ok && mq[i].r2ok) sel = i;
            end
            if (!m_vld || !stall) begin
                if (sel >= 0) begin
                    m_iss    = mq[sel];
                    m_vld    = 1'b1;
                    m_zeroed = 1'b0;
                    mq.delete(sel);
                end else begin
                    m_vld = 1'b0;
                end
            end
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                if (cdb_vld && !e.r1ok && e.t1 == cdb_tag) begin e.r1ok = 1'b1; e.r1 = cdb_data; end
                if (cdb_vld && !e.r2ok && e.t2 == cdb_tag) begin e.r2ok = 1'b1; e.r2 = cdb_data; end
                mq[i] = e;
            end
            if (disp_vld && room) begin
                e = '{disp_is_jal, disp_is_jalr, disp_op, disp_pc, disp_pred, disp_imm, disp_rob,
                      disp_r1ok, disp_r1, disp_t1, disp_r2ok, disp_r2, disp_t2};
`ifdef BR_RS_DISP_BYPASS_EN
                if (cdb_vld && !e.r1ok && e.t1 == cdb_tag) begin e.r1ok = 1'b1; e.r1 = cdb_data; end
                if (cdb_vld && !e.r2ok && e.t2 == cdb_tag) begin e.r2ok = 1'b1; e.r2 = cdb_data; end
`endif
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        chk("disp_rdy", 64'(disp_rdy), 64'(mq.size() < D));
        chk("iss_vld", 64'(iss_vld), 64'(m_vld));
        if (m_vld || m_zeroed) begin
            chk("iss_is_jal", 64'(iss_is_jal), 64'(m_iss.is_jal));
            chk("iss_is_jalr", 64'(iss_is_jalr), 64'(m_iss.is_jalr));
            chk("iss_op", 64'(iss_op), 64'(m_iss.op));
            chk("iss_pc", 64'(iss_pc), 64'(m_iss.pc));
            chk("iss_pred", 64'(iss_pred), 64'(m_iss.pred));
            chk("iss_imm", 64'(iss_imm), 64'(m_iss.imm));
            chk("iss_rs1", 64'(iss_rs1), 64'(m_iss.r1));
            chk("iss_rs2", 64'(iss_rs2), 64'(m_iss.r2));
            chk("iss_rob", 64'(iss_rob), 64'(m_iss.rob));
        end
    endtask

    task automatic idle();
        disp_vld = 1'b0;
        cdb_vld  = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic disp(input logic [PW-1:0] pc, input logic r1ok, input logic [DW-1:0] v1,
                        input logic [TW-1:0] t1, input logic r2ok, input logic [DW-1:0] v2,
                        input logic [TW-1:0] t2);
        disp_vld     = 1'b1;
        disp_is_jal  = 1'($urandom);
        disp_is_jalr = 1'($urandom);
        disp_op      = OW'($urandom);
        disp_pc      = pc;
        disp_pred    = PW'($urandom);
        disp_imm     = DW'($urandom);
        disp_rob     = TW'($urandom);
        disp_r1ok    = r1ok;
        disp_r1      = v1;
        disp_t1      = t1;
        disp_r2ok    = r2ok;
        disp_r2      = v2;
        disp_t2      = t2;
    endtask

    task automatic bcast(input logic [TW-1:0] tag, input logic [DW-1:0] data);
        cdb_vld  = 1'b1;
        cdb_tag  = tag;
        cdb_data = data;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; idle();
        disp(32'h0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd0); disp_vld = 1'b0;
        bcast(6'd0, 32'h0); cdb_vld = 1'b0;
        cycle(); cycle();
        rst_n = 1'b1;

        // BEQ with both operands ready issues two edges after dispatch
        disp(32'h100, 1'b1, 32'd5, 6'd0, 1'b1, 32'd5, 6'd0); disp_imm = 32'h20; disp_op = 4'd0;
        cycle(); idle(); cycle();
        chk("t1_vld", 64'(iss_vld), 64'd1);
        chk("t1_pc", 64'(iss_pc), 64'h100);
        chk("t1_rs1", 64'(iss_rs1), 64'd5);
        cycle();

        // rs1 woken by CDB one cycle after dispatch
        disp(32'h140, 1'b0, 32'h0, 6'd3, 1'b1, 32'd7, 6'd0);
        cycle(); idle(); bcast(6'd3, 32'hAB); cycle(); idle(); cycle();
        chk("t2_rs1", 64'(iss_rs1), 64'hAB);
        cycle();

        // ready B overtakes waiting A; then two woken together issue oldest first
        disp(32'h300, 1'b0, 32'h0, 6'd7, 1'b1, 32'd1, 6'd0); cycle();
        disp(32'h200, 1'b1, 32'd2, 6'd0, 1'b1, 32'd2, 6'd0); cycle();
        idle(); cycle();
        chk("t3_first", 64'(iss_pc), 64'h200);
        bcast(6'd7, 32'h77); cycle(); idle(); cycle();
        chk("t3_second", 64'(iss_pc), 64'h300);
        disp(32'h400, 1'b0, 32'h0, 6'd11, 1'b1, 32'd4, 6'd0); cycle();
        disp(32'h500, 1'b0, 32'h0, 6'd11, 1'b1, 32'd5, 6'd0); cycle();
        idle(); bcast(6'd11, 32'h11); cycle(); idle(); cycle();
        chk("t3_old", 64'(iss_pc), 64'h400);
        cycle();
        chk("t3_young", 64'(iss_pc), 64'h500);

        // fill, hold a fifth dispatch until a slot frees
        for (int k = 0; k < 4; k++) begin
            disp(32'h1000 + 32'(k), 1'b0, 32'h0, 6'(20 + k), 1'b1, 32'd0, 6'd0); cycle();
        end
        chk("t4_full", 64'(disp_rdy), 64'd0);
        disp(32'h600, 1'b1, 32'd6, 6'd0, 1'b1, 32'd6, 6'd0);
        cycle(); cycle();
        bcast(6'd20, 32'h20); cycle(); cdb_vld = 1'b0; cycle(); cycle();
        idle();
        for (int k = 1; k < 4; k++) begin
            bcast(6'(20 + k), 32'(k)); cycle();
        end
        idle(); cycle(); cycle(); cycle();

        // stall holds the issue stage for three cycles
        disp(32'h700, 1'b1, 32'd7, 6'd0, 1'b1, 32'd7, 6'd0); cycle();
        disp(32'h800, 1'b1, 32'd8, 6'd0, 1'b1, 32'd8, 6'd0); cycle();
        idle(); stall = 1'b1; cycle(); cycle(); cycle();
        chk("t5_hold", 64'(iss_pc), 64'h700);
        stall = 1'b0; cycle();
        chk("t5_next", 64'(iss_pc), 64'h800);
        cycle();

        // flush with waiting entries and a stalled valid issue
        disp(32'h900, 1'b1, 32'd9, 6'd0, 1'b1, 32'd9, 6'd0); cycle();
        for (int k = 0; k < 3; k++) begin
            disp(32'hA00 + 32'(k), 1'b0, 32'h0, 6'(30 + k), 1'b1, 32'd0, 6'd0); cycle();
        end
        idle(); stall = 1'b1; cycle();
        flush = 1'b1; cycle();
        flush = 1'b0; stall = 1'b0;
        chk("t6_vld", 64'(iss_vld), 64'd0);
        chk("t6_rdy", 64'(disp_rdy), 64'd1);
        for (int k = 0; k < 3; k++) begin
            bcast(6'(30 + k), 32'(k)); cycle();
        end
        idle(); cycle();
`ifdef BR_RS_DISP_BYPASS_EN
        disp(32'hB00, 1'b0, 32'h0, 6'd9, 1'b1, 32'd1, 6'd0); bcast(6'd9, 32'h99);
        cycle(); idle(); cycle();
        chk("t6_bypass_vld", 64'(iss_vld), 64'd1);
        chk("t6_bypass_rs1", 64'(iss_rs1), 64'h99);
        cycle();
`endif

        // random traffic with one mid-run reset
        for (int n = 0; n < 1500; n++) begin
            idle();
            if ($urandom_range(0, 9) < 6)
                disp(PW'($urandom), 1'($urandom), DW'($urandom), TW'($urandom_range(0, 7)),
                     1'($urandom), DW'($urandom), TW'($urandom_range(0, 7)));
            if ($urandom_range(0, 1) == 0) bcast(TW'($urandom_range(0, 7)), DW'($urandom));
`ifndef BR_RS_DISP_BYPASS_EN
            if (cdb_vld && disp_vld && ((!disp_r1ok && disp_t1 == cdb_tag) ||
                                        (!disp_r2ok && disp_t2 == cdb_tag)))
                cdb_vld = 1'b0;
`endif
            stall = ($urandom_range(0, 9) < 3);
            flush = ($urandom_range(0, 49) == 0);
            rst_n = (n != 700);
            cycle();
        end
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
